ysyx_24080006_rd_arb: RTL and testbench

//  Read-channel arbiter that shares the core's single AXI4 read master (io_master_ar*/r*) among NM

---
 rtl/ysyx_24080006_rd_arb_if.sv | 38 +++
 rtl/ysyx_24080006_rd_arb.sv | 128 ++++++++++++
 tb/tb_ysyx_24080006_rd_arb.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24080006_rd_arb_if.sv
// Bus bundle for the shared AXI4 read-channel arbiter: NM upstream requester slices plus one downstream port.
// The arbiter connects through `master` because it drives the shared downstream channel; the environment uses `slave`.
interface ysyx_24080006_rd_arb_if #(
    parameter int NM   = 2,
    parameter int AR_W = 45
);
    logic [NM-1:0]      m_arvalid;
    logic [NM-1:0]      m_arready;
    logic [NM*AR_W-1:0] m_ar;
    logic [NM-1:0]      m_rvalid;
    logic [NM-1:0]      m_rready;
    logic [NM*32-1:0]   m_rdata;
    logic [NM*2-1:0]    m_rresp;
    logic [NM-1:0]      m_rlast;

    logic               s_arvalid;
    logic               s_arready;
    logic [AR_W-1:0]    s_ar;
    logic               s_rvalid;
    logic               s_rready;
    logic [31:0]        s_rdata;
    logic [1:0]         s_rresp;
    logic               s_rlast;

    modport master (
        input  m_arvalid, m_ar, m_rready,
        input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
        output s_arvalid, s_ar, s_rready
    );

    modport slave (
        output m_arvalid, m_ar, m_rready,
        output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
        input  s_arvalid, s_ar, s_rready
    );
endinterface

// File: rtl/ysyx_24080006_rd_arb.sv
// Read-channel arbiter: shares one AXI4 read master among NM requesters (0 = IFU, 1 = LSU),
// one burst at a time, holding each grant until the final R beat and checking the beat count against arlen.
module ysyx_24080006_rd_arb #(
    parameter int NM   = 2,
    parameter bit RR   = 1'b1,
    parameter int AR_W = 45
) (
    input  logic                    clock,
    input  logic                    reset,
    ysyx_24080006_rd_arb_if.master  bus,
    output logic [NM-1:0]           grant,
    output logic                    busy,
    output logic                    len_err
);
    localparam int IW = $clog2(NM);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state;
    state_t          state_next;
    logic [AR_W-1:0] ar_q;
    logic [NM-1:0]   grant_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   last_q;
    logic [7:0]      beat_cnt;
    logic            len_err_q;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic            owner_ready;
    logic            beat;
    logic [7:0]      burst_len;

    // len sits just above size[2:0] and burst[1:0] in the packed AR payload
    assign burst_len   = ar_q[12:5];
    assign owner_ready = |(bus.m_rready & grant_q);
    assign beat        = (state == DATA) && bus.s_rvalid && owner_ready;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        if (RR) begin
            for (int k = 0; k < NM; k++) begin
                cand = IW'((int'(last_q) + 1 + k) % NM);
                if (!found && bus.m_arvalid[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end else begin
            for (int i = 0; i < NM; i++) begin
                if (bus.m_arvalid[i]) begin
                    found = 1'b1;
                    win   = IW'(i);
                end
            end
        end
    end

    always_comb begin
        state_next    = state;
        bus.m_arready = '0;
        bus.s_arvalid = 1'b0;
        bus.s_rready  = 1'b0;
        bus.m_rvalid  = '0;
        bus.m_rlast   = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    bus.m_arready = NM'(1) << win;
                    state_next    = ADDR;
                end
            end
            ADDR: begin
                bus.s_arvalid = 1'b1;
                if (bus.s_arready) state_next = DATA;
            end
            DATA: begin
                bus.s_rready = owner_ready;
                bus.m_rvalid = grant_q & {NM{bus.s_rvalid}};
                bus.m_rlast  = grant_q & {NM{bus.s_rlast}};
                if (beat && bus.s_rlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ar_q      <= '0;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= IW'(NM - 1);
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                ar_q     <= bus.m_ar[int'(win) * AR_W +: AR_W];
                grant_q  <= NM'(1) << win;
                owner_q  <= win;
                beat_cnt <= '0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + 8'd1;
                // the last beat must land exactly on index len, no earlier and no later
                if (bus.s_rlast != (beat_cnt == burst_len)) len_err_q <= 1'b1;
                if (bus.s_rlast) begin
                    grant_q <= '0;
                    last_q  <= owner_q;
                end
            end
        end
    end

    assign bus.s_ar    = ar_q;
    assign bus.m_rdata = {NM{bus.s_rdata}};
    assign bus.m_rresp = {NM{bus.s_rresp}};
    assign grant       = grant_q;
    assign busy        = (state != IDLE);
    assign len_err     = len_err_q;
endmodule

// File: tb/tb_ysyx_24080006_rd_arb.sv
// Directed bench: a round-robin and a fixed-priority arbiter run in lockstep on shared stimulus,
// with a vector table for single bursts and hand-written sequences for contention, stalls, length errors and reset.
module tb_ysyx_24080006_rd_arb;
    localparam int NM   = 2;
    localparam int AR_W = 45;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [NM-1:0]      m_arvalid;
    logic [NM*AR_W-1:0] m_ar;
    logic [NM-1:0]      m_rready;
    logic               s_arready;
    logic               s_rvalid;
    logic [31:0]        s_rdata;
    logic [1:0]         s_rresp;
    logic               s_rlast;

    ysyx_24080006_rd_arb_if #(.NM(NM), .AR_W(AR_W)) bus_rr ();
    ysyx_24080006_rd_arb_if #(.NM(NM), .AR_W(AR_W)) bus_fp ();

    assign bus_rr.m_arvalid = m_arvalid;
    assign bus_rr.m_ar      = m_ar;
    assign bus_rr.m_rready  = m_rready;
    assign bus_rr.s_arready = s_arready;
    assign bus_rr.s_rvalid  = s_rvalid;
    assign bus_rr.s_rdata   = s_rdata;
    assign bus_rr.s_rresp   = s_rresp;
    assign bus_rr.s_rlast   = s_rlast;
    assign bus_fp.m_arvalid = m_arvalid;
    assign bus_fp.m_ar      = m_ar;
    assign bus_fp.m_rready  = m_rready;
    assign bus_fp.s_arready = s_arready;
    assign bus_fp.s_rvalid  = s_rvalid;
    assign bus_fp.s_rdata   = s_rdata;
    assign bus_fp.s_rresp   = s_rresp;
    assign bus_fp.s_rlast   = s_rlast;

    logic [NM-1:0] grant_rr, grant_fp;
    logic          busy_rr, busy_fp, len_err_rr, len_err_fp;

    ysyx_24080006_rd_arb #(.NM(NM), .RR(1'b1), .AR_W(AR_W)) dut_rr (
        .clock(clock), .reset(reset), .bus(bus_rr),
        .grant(grant_rr), .busy(busy_rr), .len_err(len_err_rr)
    );
    ysyx_24080006_rd_arb #(.NM(NM), .RR(1'b0), .AR_W(AR_W)) dut_fp (
        .clock(clock), .reset(reset), .bus(bus_fp),
        .grant(grant_fp), .busy(busy_fp), .len_err(len_err_fp)
    );

    typedef struct {
        logic [1:0] req;
        logic [7:0] len;
        logic [1:0] exp_rr;
        logic [1:0] exp_fp;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    function automatic logic [AR_W-1:0] mkAr(input logic [31:0] addr, input logic [7:0] len);
        return {addr, len, 3'd2, 2'b01};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [AR_W-1:0] ar0, input logic [AR_W-1:0] ar1);
        m_arvalid = req;
        m_ar      = {ar1, ar0};
    endtask

    task automatic doReset();
        reset     = 1'b1;
        m_arvalid = '0;
        m_ar      = '0;
        m_rready  = 2'b11;
        s_arready = 1'b1;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input int n);
        logic [AR_W-1:0] ar0, ar1;
        logic [31:0]     dat;
        ar0 = mkAr(32'h3000_0000 + 32'(n * 16), v.len);
        ar1 = mkAr(32'h8000_0000 + 32'(n * 16), v.len);
        applyStimulus(v.req, ar0, ar1);
        m_rready  = 2'b11;
        s_arready = 1'b1;
        #1;
        checkOutput("vec_idle_busy", busy_rr, 1'b0);
        checkOutput("vec_arready_rr", bus_rr.m_arready, v.exp_rr);
        checkOutput("vec_arready_fp", bus_fp.m_arready, v.exp_fp);
        tick();
        m_arvalid = '0;
        #1;
        checkOutput("vec_addr_busy", busy_rr, 1'b1);
        checkOutput("vec_grant_rr", grant_rr, v.exp_rr);
        checkOutput("vec_grant_fp", grant_fp, v.exp_fp);
        checkOutput("vec_s_arvalid", bus_rr.s_arvalid, 1'b1);
        checkOutput("vec_s_ar_rr", bus_rr.s_ar, (v.exp_rr == 2'b01) ? ar0 : ar1);
        checkOutput("vec_s_ar_fp", bus_fp.s_ar, (v.exp_fp == 2'b01) ? ar0 : ar1);
        tick();
        for (int b = 0; b <= int'(v.len); b++) begin
            dat      = 32'hD000_0000 + 32'(n * 256 + b);
            s_rvalid = 1'b1;
            s_rdata  = dat;
            s_rresp  = 2'(b);
            s_rlast  = (b == int'(v.len));
            #1;
            checkOutput("vec_rvalid_rr", bus_rr.m_rvalid, v.exp_rr);
            checkOutput("vec_rlast_rr", bus_rr.m_rlast, (b == int'(v.len)) ? v.exp_rr : 2'b00);
            checkOutput("vec_rdata_rr", bus_rr.m_rdata, {2{dat}});
            checkOutput("vec_rresp_rr", bus_rr.m_rresp, {2{2'(b)}});
            checkOutput("vec_s_rready", bus_rr.s_rready, 1'b1);
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        checkOutput("vec_end_busy", busy_rr, 1'b0);
        checkOutput("vec_end_grant", grant_rr, 2'b00);
        checkOutput("vec_end_len_err", len_err_rr, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t         vecs[7];
        logic [1:0]   exp_rr_seq[4];
        logic [5:0]   rdy_sched;
        int           b;

        vecs[0] = '{req: 2'b01, len: 8'd0, exp_rr: 2'b01, exp_fp: 2'b01};
        vecs[1] = '{req: 2'b10, len: 8'd1, exp_rr: 2'b10, exp_fp: 2'b10};
        vecs[2] = '{req: 2'b11, len: 8'd0, exp_rr: 2'b01, exp_fp: 2'b10};
        vecs[3] = '{req: 2'b11, len: 8'd2, exp_rr: 2'b10, exp_fp: 2'b10};
        vecs[4] = '{req: 2'b11, len: 8'd0, exp_rr: 2'b01, exp_fp: 2'b10};
        vecs[5] = '{req: 2'b01, len: 8'd3, exp_rr: 2'b01, exp_fp: 2'b01};
        vecs[6] = '{req: 2'b11, len: 8'd0, exp_rr: 2'b10, exp_fp: 2'b10};
        exp_rr_seq[0] = 2'b01;
        exp_rr_seq[1] = 2'b10;
        exp_rr_seq[2] = 2'b01;
        exp_rr_seq[3] = 2'b10;

        $display("[TB] reset state");
        doReset();
        #1;
        checkOutput("rst_busy", busy_rr, 1'b0);
        checkOutput("rst_grant", grant_rr, 2'b00);
        checkOutput("rst_len_err", len_err_rr, 1'b0);
        checkOutput("rst_s_arvalid", bus_rr.s_arvalid, 1'b0);
        checkOutput("rst_s_rready", bus_rr.s_rready, 1'b0);
        checkOutput("rst_s_ar", bus_rr.s_ar, '0);

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) runVector(vecs[i], i);

        $display("[TB] sustained contention");
        doReset();
        applyStimulus(2'b11, mkAr(32'h3000_0100, 8'd0), mkAr(32'h8000_0100, 8'd0));
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("cont_idle_busy", busy_rr, 1'b0);
            checkOutput("cont_arready_rr", bus_rr.m_arready, exp_rr_seq[k]);
            checkOutput("cont_arready_fp", bus_fp.m_arready, 2'b10);
            tick();
            #1;
            checkOutput("cont_busy_no_arready", bus_rr.m_arready, 2'b00);
            checkOutput("cont_grant_rr", grant_rr, exp_rr_seq[k]);
            checkOutput("cont_grant_fp", grant_fp, 2'b10);
            tick();
            s_rvalid = 1'b1;
            s_rlast  = 1'b1;
            s_rdata  = 32'h1234_0000 + 32'(k);
            #1;
            checkOutput("cont_rvalid_rr", bus_rr.m_rvalid, exp_rr_seq[k]);
            tick();
            s_rvalid = 1'b0;
            s_rlast  = 1'b0;
        end
        m_arvalid = '0;

        $display("[TB] LSU burst with owner stall");
        tick();
        applyStimulus(2'b10, '0, mkAr(32'h8000_1000, 8'd3));
        #1;
        checkOutput("stall_arready", bus_rr.m_arready, 2'b10);
        tick();
        m_arvalid = '0;
        tick();
        rdy_sched = 6'b111001;
        b = 0;
        for (int c = 0; c < 6; c++) begin
            m_rready = {rdy_sched[c], 1'b1};
            s_rvalid = 1'b1;
            s_rdata  = 32'hA000_0000 + 32'(b);
            s_rlast  = (b == 3);
            #1;
            checkOutput("stall_s_rready", bus_rr.s_rready, rdy_sched[c]);
            checkOutput("stall_rvalid", bus_rr.m_rvalid, 2'b10);
            checkOutput("stall_rlast", bus_rr.m_rlast, (b == 3) ? 2'b10 : 2'b00);
            checkOutput("stall_rdata", bus_rr.m_rdata[63:32], 32'hA000_0000 + 32'(b));
            if (rdy_sched[c]) b++;
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        m_rready = 2'b11;
        #1;
        checkOutput("stall_done_busy", busy_rr, 1'b0);
        checkOutput("stall_len_err", len_err_rr, 1'b0);

        $display("[TB] early rlast");
        applyStimulus(2'b01, mkAr(32'h3000_2000, 8'd3), '0);
        tick();
        m_arvalid = '0;
        tick();
        for (int i = 0; i < 2; i++) begin
            s_rvalid = 1'b1;
            s_rlast  = (i == 1);
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        checkOutput("early_busy", busy_rr, 1'b0);
        checkOutput("early_len_err", len_err_rr, 1'b1);
        tick();
        #1;
        checkOutput("early_len_err_sticky", len_err_rr, 1'b1);

        $display("[TB] late rlast");
        doReset();
        #1;
        checkOutput("late_rst_len_err", len_err_rr, 1'b0);
        applyStimulus(2'b01, mkAr(32'h3000_3000, 8'd3), '0);
        tick();
        m_arvalid = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            s_rvalid = 1'b1;
            s_rlast  = (i == 4);
            #1;
            if (i == 4) begin
                checkOutput("late_len_err", len_err_rr, 1'b1);
                checkOutput("late_still_data", busy_rr, 1'b1);
            end
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        checkOutput("late_done_busy", busy_rr, 1'b0);

        $display("[TB] reset mid-burst");
        applyStimulus(2'b10, '0, mkAr(32'h8000_4000, 8'd3));
        tick();
        m_arvalid = '0;
        tick();
        for (int i = 0; i < 2; i++) begin
            s_rvalid = 1'b1;
            tick();
        end
        s_rvalid = 1'b1;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        s_rvalid = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy_rr, 1'b0);
        checkOutput("mid_rst_grant", grant_rr, 2'b00);
        checkOutput("mid_rst_s_rready", bus_rr.s_rready, 1'b0);
        checkOutput("mid_rst_s_arvalid", bus_rr.s_arvalid, 1'b0);
        checkOutput("mid_rst_len_err", len_err_rr, 1'b0);
        applyStimulus(2'b11, mkAr(32'h3000_5000, 8'd0), mkAr(32'h8000_5000, 8'd0));
        #1;
        checkOutput("mid_rst_arready_rr", bus_rr.m_arready, 2'b01);
        checkOutput("mid_rst_arready_fp", bus_fp.m_arready, 2'b10);
        tick();
        m_arvalid = '0;
        #1;
        checkOutput("mid_rst_grant_rr", grant_rr, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
